// File: rtl/sid_regbank_pkg.sv
// rtl/sid_regbank_pkg.sv - register map constants and helpers shared by the SID register front-end
package sid_regbank_pkg;

    localparam int NUM_WREGS = 25;

    localparam logic [4:0] REG_V1_FREQ_LO = 5'h00;
    localparam logic [4:0] REG_V1_FREQ_HI = 5'h01;
    localparam logic [4:0] REG_V1_PW_LO   = 5'h02;
    localparam logic [4:0] REG_V1_PW_HI   = 5'h03;
    localparam logic [4:0] REG_V1_CTRL    = 5'h04;
    localparam logic [4:0] REG_V1_AD      = 5'h05;
    localparam logic [4:0] REG_V1_SR      = 5'h06;
    localparam logic [4:0] REG_V2_FREQ_LO = 5'h07;
    localparam logic [4:0] REG_V2_FREQ_HI = 5'h08;
    localparam logic [4:0] REG_V2_PW_LO   = 5'h09;
    localparam logic [4:0] REG_V2_PW_HI   = 5'h0A;
    localparam logic [4:0] REG_V2_CTRL    = 5'h0B;
    localparam logic [4:0] REG_V2_AD      = 5'h0C;
    localparam logic [4:0] REG_V2_SR      = 5'h0D;
    localparam logic [4:0] REG_V3_FREQ_LO = 5'h0E;
    localparam logic [4:0] REG_V3_FREQ_HI = 5'h0F;
    localparam logic [4:0] REG_V3_PW_LO   = 5'h10;
    localparam logic [4:0] REG_V3_PW_HI   = 5'h11;
    localparam logic [4:0] REG_V3_CTRL    = 5'h12;
    localparam logic [4:0] REG_V3_AD      = 5'h13;
    localparam logic [4:0] REG_V3_SR      = 5'h14;
    localparam logic [4:0] REG_FC_LO      = 5'h15;
    localparam logic [4:0] REG_FC_HI      = 5'h16;
    localparam logic [4:0] REG_RES_FILT   = 5'h17;
    localparam logic [4:0] REG_MODE_VOL   = 5'h18;
    localparam logic [4:0] REG_POTX       = 5'h19;
    localparam logic [4:0] REG_POTY       = 5'h1A;
    localparam logic [4:0] REG_OSC3       = 5'h1B;
    localparam logic [4:0] REG_ENV3       = 5'h1C;

    localparam logic [4:0] PW_HI_IDX [3] = '{REG_V1_PW_HI, REG_V2_PW_HI, REG_V3_PW_HI};

    // Pulse-width high registers only implement the low nibble.
    function automatic logic is_pw_hi(input logic [4:0] idx);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (idx == PW_HI_IDX[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/sid_bus_channel.sv
// rtl/sid_bus_channel.sv - per-core register array, decaying bus latch and pot sampler
module sid_bus_channel
    import sid_regbank_pkg::*;
#(
    parameter int DECAY_TICKS = 8000,
    parameter int POT_PERIOD  = 512
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ce_1m,
    input  logic                   wr_en,
    input  logic [4:0]             wr_idx,
    input  logic [7:0]             wr_data,
    input  logic                   rd_load,
    input  logic [7:0]             rd_data,
    input  logic [7:0]             pot_x,
    input  logic [7:0]             pot_y,
    output logic [7:0]             bus_latch,
    output logic [7:0]             pot_x_smp,
    output logic [7:0]             pot_y_smp,
    output logic [NUM_WREGS*8-1:0] regs
);

    localparam int DW = $clog2(DECAY_TICKS + 1);
    localparam int PW = $clog2(POT_PERIOD);

    logic [DW-1:0] decay_cnt;
    logic [PW-1:0] pot_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_latch <= '0;
            decay_cnt <= '0;
            pot_cnt   <= '0;
            pot_x_smp <= '0;
            pot_y_smp <= '0;
            regs      <= '0;
        end else begin
            // An access reload takes priority over the decay step in the same cycle.
            if (wr_en) begin
                bus_latch <= wr_data;
                decay_cnt <= DW'(DECAY_TICKS);
            end else if (rd_load) begin
                bus_latch <= rd_data;
                decay_cnt <= DW'(DECAY_TICKS);
            end else if (ce_1m && decay_cnt != '0) begin
                decay_cnt <= decay_cnt - DW'(1);
                if (decay_cnt == DW'(1)) bus_latch <= '0;
            end

            if (ce_1m) begin
                if (pot_cnt == PW'(POT_PERIOD - 1)) begin
                    pot_cnt   <= '0;
                    pot_x_smp <= pot_x;
                    pot_y_smp <= pot_y;
                end else begin
                    pot_cnt <= pot_cnt + PW'(1);
                end
            end

            if (wr_en) begin
                for (int r = 0; r < NUM_WREGS; r++) begin
                    if (wr_idx == 5'(r)) begin
                        regs[r*8 +: 8] <= is_pw_hi(wr_idx) ? {4'h0, wr_data[3:0]} : wr_data;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/sid_regbank_multi.sv
// rtl/sid_regbank_multi.sv - multi-core SID register front-end: decode, arbitration and readback
module sid_regbank_multi
    import sid_regbank_pkg::*;
#(
    parameter int NUM_SID     = 2,
    parameter int SEL_W       = 1,
    parameter int DECAY_TICKS = 8000,
    parameter int POT_PERIOD  = 512
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ce_1m,
    input  logic                     we,
    input  logic                     re,
    input  logic [SEL_W+4:0]         addr,
    input  logic [7:0]               data_in,
    output logic [7:0]               data_out,
    output logic                     rd_valid,
    input  logic [NUM_SID*8-1:0]     pot_x,
    input  logic [NUM_SID*8-1:0]     pot_y,
    input  logic [NUM_SID*8-1:0]     osc3,
    input  logic [NUM_SID*8-1:0]     env3,
    output logic [NUM_SID*200-1:0]   regs
);

    logic [SEL_W-1:0]     sel;
    logic [4:0]           idx;
    logic [2**SEL_W-1:0]  sel_map;
    logic                 sel_ok;
    logic                 wr_fire;
    logic                 rd_fire;
    logic [7:0]           rd_data;
    logic [7:0]           latch_a [NUM_SID];
    logic [7:0]           potx_a  [NUM_SID];
    logic [7:0]           poty_a  [NUM_SID];

    assign sel = addr[SEL_W+4:5];
    assign idx = addr[4:0];

    always_comb begin
        sel_map = '0;
        for (int s = 0; s < 2**SEL_W; s++) sel_map[s] = (s < NUM_SID);
    end

    assign sel_ok  = sel_map[sel];
    assign wr_fire = we && sel_ok;
    // A write in the same cycle wins; the read is dropped entirely.
    assign rd_fire = re && !we;

    always_comb begin
        rd_data = 8'h00;
        for (int s = 0; s < NUM_SID; s++) begin
            if (sel_ok && sel == SEL_W'(s)) begin
                case (idx)
                    REG_POTX: rd_data = potx_a[s];
                    REG_POTY: rd_data = poty_a[s];
                    REG_OSC3: rd_data = osc3[s*8 +: 8];
                    REG_ENV3: rd_data = env3[s*8 +: 8];
                    default:  rd_data = latch_a[s];
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_SID; g++) begin : g_ch
        sid_bus_channel #(
            .DECAY_TICKS(DECAY_TICKS),
            .POT_PERIOD (POT_PERIOD)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .ce_1m    (ce_1m),
            .wr_en    (wr_fire && sel == SEL_W'(g)),
            .wr_idx   (idx),
            .wr_data  (data_in),
            .rd_load  (rd_fire && sel_ok && sel == SEL_W'(g)),
            .rd_data  (rd_data),
            .pot_x    (pot_x[g*8 +: 8]),
            .pot_y    (pot_y[g*8 +: 8]),
            .bus_latch(latch_a[g]),
            .pot_x_smp(potx_a[g]),
            .pot_y_smp(poty_a[g]),
            .regs     (regs[g*200 +: 200])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= 8'h00;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) data_out <= rd_data;
        end
    end

endmodule

// File: doc/sid_regbank_multi.md
Name: sid_regbank_multi

Overview:
- Parametrised register front-end for NUM_SID SID cores sharing one CPU bus.
- Decodes a select-plus-register address and holds each core's 25 write-only registers.
- Adds SID bus behaviour the single-core decoder lacks: a data-bus latch that decays, a sampled POTX/POTY every POT_PERIOD ticks, and registered readback with a valid strobe.
- Sits between the CPU bus and NUM_SID sid_voice/sid_filters clusters.

Parameters:
- NUM_SID, 2: number of SID cores; must satisfy 1 <= NUM_SID <= 2**SEL_W.
- SEL_W, 1: width of the core-select field in addr.
- DECAY_TICKS, 8000: ce_1m ticks after a bus access before the bus latch reads 0x00; must be >= 1.
- POT_PERIOD, 512: ce_1m ticks between pot samples; must be >= 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ce_1m  in  1  1 MHz clock enable; one clk wide.
- we  in  1  write strobe; one clk per access.
- re  in  1  read strobe; one clk per access.
- addr  in  SEL_W+5  {core select, register index 0x00-0x1F}.
- data_in  in  8  write data.
- data_out  out  8  registered read data.
- rd_valid  out  1  one-clk pulse; data_out is valid on this cycle.
- pot_x  in  NUM_SID*8  per-core raw POTX, packed with core 0 at LSB.
- pot_y  in  NUM_SID*8  per-core raw POTY.
- osc3  in  NUM_SID*8  per-core OSC3 readback.
- env3  in  NUM_SID*8  per-core ENV3 readback.
- regs  out  NUM_SID*200  per-core registers 0x00-0x18 packed; reg r of core s is at bits [s*200+r*8 +: 8].

Behaviour:
- Reset, synchronous, active-high on clk:
  - all regs, bus latches, decay counters, pot counters and pot samples clear to 0;
  - data_out = 0x00, rd_valid = 0.
  - Reset asserted mid-access discards that access.
- Write, we=1, sel<NUM_SID, idx<=0x18:
  - the register updates on the next clk edge, 1-cycle latency to regs.
  - idx 0x03, 0x0A, 0x11 store {4'h0, data_in[3:0]}.
- Write to idx 0x19-0x1F: no register change.
- Write with sel>=NUM_SID: fully ignored, no latch or counter effect.
- Every write with a valid sel loads that core's bus latch with data_in and reloads its decay counter to DECAY_TICKS.
- Decay:
  - per core, on ce_1m with counter>0, the counter decrements;
  - on the 1->0 transition the latch clears to 0x00;
  - the counter holds at 0.
  - A same-cycle write or read reload beats the decrement/clear.
- Pot sampler:
  - per-core free-running counter 0..POT_PERIOD-1, advancing on ce_1m;
  - on the ce_1m where the counter equals POT_PERIOD-1 it wraps to 0 and captures pot_x/pot_y for that core.
  - The first sample lands POT_PERIOD ce_1m ticks after reset.
- Read, re=1 and we=0:
  - data_out and rd_valid update on the next clk edge, 1-cycle latency;
  - rd_valid is high for exactly one clk.
  - Data by idx:
    - 0x19: sampled POTX;
    - 0x1A: sampled POTY;
    - 0x1B: osc3 of the core, captured at the read edge;
    - 0x1C: env3 of the core;
    - all other idx: the bus latch.
  - A read with valid sel loads the bus latch with the returned value and reloads the decay counter.
  - A read with sel>=NUM_SID returns 0x00 with rd_valid=1 and touches no state.
- we and re in the same clk: the write executes, the read is dropped, rd_valid stays 0.
- data_out holds its value between reads.
- ce_1m does not gate bus accesses; accesses are processed on any clk.
- Widths:
  - decay counter is $clog2(DECAY_TICKS+1) bits;
  - pot counter is $clog2(POT_PERIOD) bits;
  - no overflow is possible.

Decomposition:
- Package sid_regbank_pkg holds:
  - register index constants (REG_V1_FREQ_LO..REG_MODE_VOL, REG_POTX, REG_POTY, REG_OSC3, REG_ENV3);
  - NUM_WREGS=25;
  - the PW_HI index list used for nibble masking.
- Sub-module sid_bus_channel, instanced NUM_SID times via generate, holds:
  - bus latch plus decay counter;
  - pot counter plus samples;
  - the 25-byte register array.
- The top level holds address decode, read mux, data_out/rd_valid and the we/re arbitration.

Test Plan:
- Reset then write core1 idx 0x03 = 0xA7 -> regs[1*200+24 +: 8]=0x07 one clk later; core0 bank unchanged, all 0.
- DECAY_TICKS=4: write core0 idx 0x00=0x5A, then read idx 0x1F after 3 ce_1m -> 0x5A. Read reloads, so do a fresh write and read after 4 ce_1m -> 0x00.
- POT_PERIOD=4, pot_x core0=0x33: read idx 0x19 before the 4th ce_1m -> 0x00. After it -> 0x33, rd_valid one clk, data_out valid exactly 1 clk after re.
- osc3 core1=0xC4, read sel=1 idx 0x1B -> 0xC4. Then read idx 0x05 -> 0xC4, the latch refreshed by the prior read.
- we and re same clk, write core0 idx 0x18=0x0F -> reg updated, rd_valid=0. NUM_SID=3 with SEL_W=2: a write to sel=3 changes nothing, a read of sel=3 returns 0x00 with rd_valid=1.
- Assert reset during a pending read cycle with decay counters mid-count -> data_out=0x00, rd_valid=0, all latches 0 the next clk.
